// File: rtl/data_memory_ctrl.sv
// data_memory_ctrl: byte-addressed data memory with a valid/ready request
// port, a registered one-cycle response, programmable wait states and a
// self-clearing array after reset.
//
// Optional build macro: DMEM_MISALIGN_CHECK_EN
//   defined   - misaligned half/word accesses are rejected with resp_err.
//   undefined - low address bits are forced to alignment for half/word.
module data_memory_ctrl #(
  parameter int DEPTH       = 256,
  parameter int ADDR_WIDTH  = 32,
  parameter int WAIT_CYCLES = 0
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [1:0]            req_size,
  input  logic                  req_unsigned,
  input  logic [ADDR_WIDTH-1:0] address,
  input  logic [31:0]           data_in,
  output logic                  resp_valid,
  output logic [31:0]           data_out,
  output logic                  resp_err,
  output logic                  init_done
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam logic [ADDR_WIDTH-3:0] DEPTH_W   = (ADDR_WIDTH-2)'(DEPTH);
  localparam logic [IDX_W-1:0]      LAST_IDX  = IDX_W'(DEPTH - 1);
  localparam logic [3:0]            WAIT_INIT = 4'(WAIT_CYCLES);

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_RSVD = 2'b11;

  typedef enum logic [1:0] {
    S_CLEAR = 2'd0,
    S_IDLE  = 2'd1,
    S_BUSY  = 2'd2,
    S_RESP  = 2'd3
  } state_e;

  state_e state_q, state_d;

  // Latched request
  logic                  wr_q,    wr_d;
  logic [1:0]            size_q,  size_d;
  logic                  uns_q,   uns_d;
  logic [ADDR_WIDTH-1:0] addr_q,  addr_d;
  logic [31:0]           wdata_q, wdata_d;

  // Sequencing and response
  logic [3:0]            cnt_q,   cnt_d;
  logic [IDX_W-1:0]      clr_q,   clr_d;
  logic [31:0]           dout_q,  dout_d;
  logic                  err_q,   err_d;
  logic                  init_q,  init_d;

  // Storage and its single write port
  logic [31:0]           mem_q [DEPTH];
  logic                  mem_we;
  logic [IDX_W-1:0]      mem_widx;
  logic [31:0]           mem_wdata;

  // Access decode of the latched request
  logic [ADDR_WIDTH-3:0] widx;
  logic [IDX_W-1:0]      midx;
  logic [1:0]            lane;
  logic                  range_err;
  logic                  size_err;
  logic                  align_err;
  logic                  acc_err;
  logic                  access;
  logic [31:0]           rd_word;

  // Right-justify the selected byte/half and extend it; words pass through.
  function automatic logic [31:0] load_extract(input logic [31:0] word,
                                               input logic [1:0]  ln,
                                               input logic [1:0]  sz,
                                               input logic        uns);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    b = word[{ln, 3'b000} +: 8];
    h = word[{ln[1], 4'b0000} +: 16];
    case (sz)
      SZ_BYTE: r = uns ? {24'h0, b} : {{24{b[7]}}, b};
      SZ_HALF: r = uns ? {16'h0, h} : {{16{h[15]}}, h};
      default: r = word;
    endcase
    return r;
  endfunction

  // Replace only the addressed lanes of a word with right-justified store data.
  function automatic logic [31:0] store_merge(input logic [31:0] word,
                                              input logic [1:0]  ln,
                                              input logic [1:0]  sz,
                                              input logic [31:0] din);
    logic [31:0] r;
    r = word;
    case (sz)
      SZ_BYTE: r[{ln, 3'b000} +: 8]     = din[7:0];
      SZ_HALF: r[{ln[1], 4'b0000} +: 16] = din[15:0];
      default: r = din;
    endcase
    return r;
  endfunction

  assign widx      = addr_q[ADDR_WIDTH-1:2];
  assign midx      = widx[IDX_W-1:0];
  assign range_err = (widx >= DEPTH_W);
  assign size_err  = (size_q == SZ_RSVD);
  assign access    = (state_q == S_BUSY) && (cnt_q == 4'd0);
  assign rd_word   = mem_q[midx];

`ifdef DMEM_MISALIGN_CHECK_EN
  // Misaligned halves/words are rejected; lane is used as given.
  assign align_err = ((size_q == SZ_HALF) && addr_q[0]) ||
                     ((size_q == SZ_WORD) && (addr_q[1:0] != 2'b00));
  assign lane      = addr_q[1:0];
`else
  // Misaligned halves/words are silently aligned down.
  assign align_err = 1'b0;
  assign lane      = (size_q == SZ_HALF) ? {addr_q[1], 1'b0} :
                     (size_q == SZ_WORD) ? 2'b00 : addr_q[1:0];
`endif

  assign acc_err = range_err | size_err | align_err;

  // FSM state register; reset restarts the clear sequence and drops any access
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= S_CLEAR;
    else          state_q <= state_d;
  end

  // FSM next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_CLEAR: if (clr_q == LAST_IDX) state_d = S_IDLE;
      S_IDLE:  if (req_valid)         state_d = S_BUSY;
      S_BUSY:  if (cnt_q == 4'd0)     state_d = S_RESP;
      S_RESP:                         state_d = S_IDLE;
      default:                        state_d = S_CLEAR;
    endcase
  end

  // FSM outputs: handshake, response strobe and the array write port
  always_comb begin
    req_ready  = (state_q == S_IDLE);
    resp_valid = (state_q == S_RESP);
    mem_we     = 1'b0;
    mem_widx   = midx;
    mem_wdata  = store_merge(rd_word, lane, size_q, wdata_q);
    if (state_q == S_CLEAR) begin
      mem_we    = 1'b1;
      mem_widx  = clr_q;
      mem_wdata = 32'h0;
    end else if (access && wr_q && !acc_err) begin
      mem_we    = 1'b1;
    end
  end

  // Datapath next-state: request latch, wait counter, clear index, response
  always_comb begin
    wr_d    = wr_q;
    size_d  = size_q;
    uns_d   = uns_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    cnt_d   = cnt_q;
    clr_d   = clr_q;
    dout_d  = dout_q;
    err_d   = err_q;
    init_d  = init_q;
    case (state_q)
      S_CLEAR: begin
        clr_d = clr_q + 1'b1;
        if (clr_q == LAST_IDX) init_d = 1'b1;
      end
      S_IDLE: begin
        if (req_valid) begin
          wr_d    = req_write;
          size_d  = req_size;
          uns_d   = req_unsigned;
          addr_d  = address;
          wdata_d = data_in;
          cnt_d   = WAIT_INIT;
        end
      end
      S_BUSY: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 1'b1;
        end else begin
          err_d  = acc_err;
          dout_d = (acc_err || wr_q) ? 32'h0
                                     : load_extract(rd_word, lane, size_q, uns_q);
        end
      end
      default: ;
    endcase
  end

  // Datapath registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_q    <= 1'b0;
      size_q  <= 2'b00;
      uns_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= 32'h0;
      cnt_q   <= 4'd0;
      clr_q   <= '0;
      dout_q  <= 32'h0;
      err_q   <= 1'b0;
      init_q  <= 1'b0;
    end else begin
      wr_q    <= wr_d;
      size_q  <= size_d;
      uns_q   <= uns_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      cnt_q   <= cnt_d;
      clr_q   <= clr_d;
      dout_q  <= dout_d;
      err_q   <= err_d;
      init_q  <= init_d;
    end
  end

  // Memory array write; contents are initialised by the clear sequence
  always_ff @(posedge clk) begin
    if (mem_we) mem_q[mem_widx] <= mem_wdata;
  end

  assign data_out  = dout_q;
  assign resp_err  = err_q;
  assign init_done = init_q;

endmodule

// File: tb/tb_data_memory_ctrl.sv
// Testbench for data_memory_ctrl: directed steps plus randomized traffic,
// checked against a byte-array reference model.
module tb_data_memory_ctrl;

  localparam int DEPTH = 256;
  localparam int AW    = 32;
  localparam int W     = 2;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic          req_write = 1'b0;
  logic [1:0]    req_size = 2'b00;
  logic          req_unsigned = 1'b0;
  logic [AW-1:0] address = '0;
  logic [31:0]   data_in = 32'h0;
  logic          resp_valid;
  logic [31:0]   data_out;
  logic          resp_err;
  logic          init_done;

  int n_cmp = 0;
  int n_err = 0;

  logic [7:0] mbytes [DEPTH*4];

  always #5 clk = ~clk;

  data_memory_ctrl #(
    .DEPTH(DEPTH), .ADDR_WIDTH(AW), .WAIT_CYCLES(W)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_write(req_write), .req_size(req_size), .req_unsigned(req_unsigned),
    .address(address), .data_in(data_in),
    .resp_valid(resp_valid), .data_out(data_out),
    .resp_err(resp_err), .init_done(init_done)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference: memory as a flat little-endian byte array.
  task automatic model(input logic wr, input logic [1:0] size, input logic uns,
                       input logic [31:0] addr, input logic [31:0] din,
                       output logic [31:0] edout, output logic eerr);
    int nb;
    logic [31:0] base;
    logic [31:0] val;
    eerr = ((addr >> 2) >= DEPTH) || (size == 2'b11);
`ifdef DMEM_MISALIGN_CHECK_EN
    if (size == 2'b01 && addr[0]) eerr = 1'b1;
    if (size == 2'b10 && addr[1:0] != 2'b00) eerr = 1'b1;
`endif
    nb    = (size == 2'b00) ? 1 : (size == 2'b01) ? 2 : 4;
    base  = addr - (addr % nb);
    edout = 32'h0;
    if (!eerr) begin
      if (wr) begin
        for (int i = 0; i < nb; i++) mbytes[base + i] = 8'(din >> (8 * i));
      end else begin
        val = 32'h0;
        for (int i = 0; i < nb; i++) val |= 32'(mbytes[base + i]) << (8 * i);
        if (!uns && nb < 4 && val[8 * nb - 1]) val |= 32'hFFFF_FFFF << (8 * nb);
        edout = val;
      end
    end
  endtask

  task automatic reset_and_clear(input int hold);
    int n;
    reset_n   = 1'b0;
    req_valid = 1'b0;
    #1;
    chk("rst_req_ready",  32'(req_ready),  32'd0);
    chk("rst_resp_valid", 32'(resp_valid), 32'd0);
    chk("rst_data_out",   data_out,        32'h0);
    chk("rst_resp_err",   32'(resp_err),   32'd0);
    chk("rst_init_done",  32'(init_done),  32'd0);
    repeat (hold) @(negedge clk);
    reset_n = 1'b1;
    for (int i = 0; i < DEPTH * 4; i++) mbytes[i] = 8'h00;
    n = 0;
    while (!req_ready && n < DEPTH + 50) begin
      @(posedge clk);
      n++;
      @(negedge clk);
    end
    chk("clear_cycles", 32'(n), 32'(DEPTH));
    chk("init_done_set", 32'(init_done), 32'd1);
  endtask

  // One full transaction: wait for ready, present, check latency and response.
  task automatic do_req(input string tag, input logic wr, input logic [1:0] size,
                        input logic uns, input logic [31:0] addr, input logic [31:0] din,
                        output logic [31:0] got, output logic gerr);
    logic [31:0] edout;
    logic        eerr;
    int n;
    int edges;
    n = 0;
    while (!req_ready && n < 2000) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_ready"}, 32'(req_ready), 32'd1);
    req_valid    = 1'b1;
    req_write    = wr;
    req_size     = size;
    req_unsigned = uns;
    address      = addr;
    data_in      = din;
    model(wr, size, uns, addr, din, edout, eerr);
    @(posedge clk);
    @(negedge clk);
    req_valid    = 1'b0;
    req_write    = 1'($urandom);
    req_size     = 2'($urandom);
    req_unsigned = 1'($urandom);
    address      = $urandom;
    data_in      = $urandom;
    chk({tag, "_busy_ready"}, 32'(req_ready), 32'd0);
    edges = 0;
    while (!resp_valid && edges < 64) begin
      @(posedge clk);
      edges++;
      @(negedge clk);
    end
    chk({tag, "_latency"}, 32'(edges), 32'(W + 1));
    chk({tag, "_dout"}, data_out, edout);
    chk({tag, "_err"}, 32'(resp_err), 32'(eerr));
    got  = data_out;
    gerr = resp_err;
    @(negedge clk);
    chk({tag, "_pulse"}, 32'(resp_valid), 32'd0);
    chk({tag, "_hold"}, data_out, edout);
  endtask

  initial begin
    logic [31:0] got;
    logic        gerr;
    logic [31:0] ra;
    logic [1:0]  rs;
    int          r;

    reset_and_clear(3);

    do_req("ld_after_clear", 1'b0, 2'b10, 1'b0, 32'h3C, 32'h0, got, gerr);
    chk("ld_after_clear_lit", got, 32'h0);

    do_req("st_w10", 1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF, got, gerr);
    chk("st_w10_dout_lit", got, 32'h0);
    do_req("ld_w10", 1'b0, 2'b10, 1'b0, 32'h10, 32'h0, got, gerr);
    chk("ld_w10_lit", got, 32'hDEADBEEF);
    chk("ld_w10_err_lit", 32'(gerr), 32'd0);

    do_req("st_b11", 1'b1, 2'b00, 1'b0, 32'h11, 32'h0000007F, got, gerr);
    do_req("ld_w10b", 1'b0, 2'b10, 1'b0, 32'h10, 32'h0, got, gerr);
    chk("ld_w10b_lit", got, 32'hDEAD7FEF);
    do_req("ld_sb13", 1'b0, 2'b00, 1'b0, 32'h13, 32'h0, got, gerr);
    chk("ld_sb13_lit", got, 32'hFFFFFFDE);
    do_req("ld_uh12", 1'b0, 2'b01, 1'b1, 32'h12, 32'h0, got, gerr);
    chk("ld_uh12_lit", got, 32'h0000DEAD);
    do_req("ld_ub10", 1'b0, 2'b00, 1'b1, 32'h10, 32'h0, got, gerr);
    chk("ld_ub10_lit", got, 32'h000000EF);

    do_req("ld_oor", 1'b0, 2'b10, 1'b0, 32'h400, 32'h0, got, gerr);
    chk("ld_oor_err_lit", 32'(gerr), 32'd1);
    chk("ld_oor_dout_lit", got, 32'h0);
    do_req("ld_rsvd", 1'b0, 2'b11, 1'b0, 32'h10, 32'h0, got, gerr);
    chk("ld_rsvd_err_lit", 32'(gerr), 32'd1);

    do_req("st_w12", 1'b1, 2'b10, 1'b0, 32'h12, 32'hCAFEF00D, got, gerr);
    do_req("ld_w10c", 1'b0, 2'b10, 1'b0, 32'h10, 32'h0, got, gerr);
`ifdef DMEM_MISALIGN_CHECK_EN
    chk("ld_w10c_lit", got, 32'hDEAD7FEF);
`else
    chk("ld_w10c_lit", got, 32'hCAFEF00D);
`endif

    for (int i = 0; i < 200; i++) begin
      r  = $urandom_range(0, 15);
      ra = (r == 0) ? $urandom : (r < 4) ? 32'($urandom_range(0, DEPTH * 4 - 1))
                                         : 32'($urandom_range(0, 63));
      rs = ($urandom_range(0, 15) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
      do_req("rnd", 1'($urandom), rs, 1'($urandom), ra, $urandom, got, gerr);
    end

    // Reset while a store is waiting in BUSY.
    do_req("ld_pre_rst", 1'b0, 2'b10, 1'b0, 32'h10, 32'h0, got, gerr);
    while (!req_ready) @(negedge clk);
    req_valid = 1'b1;
    req_write = 1'b1;
    req_size  = 2'b10;
    address   = 32'h20;
    data_in   = 32'h12345678;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    reset_and_clear(2);
    do_req("ld_post_rst", 1'b0, 2'b10, 1'b0, 32'h20, 32'h0, got, gerr);
    chk("ld_post_rst_lit", got, 32'h0);
    do_req("ld_post_rst10", 1'b0, 2'b10, 1'b0, 32'h10, 32'h0, got, gerr);
    chk("ld_post_rst10_lit", got, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
